instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of `control_unit`. Holds the PC and issues one read per instruction to a variable-latency instruction memory. Captures the returned word and presents it, with its opcode field, to decode and control through a valid/ready handshake. When decode accepts an instruction, the block computes the next PC from the control/ALU outcome (sequential, taken `beq`, or `j`).

---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read per instruction, and hands the
// returned word to decode through a valid/ready handshake.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_FETCH | request cycle: imem_req=1, imem_addr=pc
// S_WAIT  | waiting on imem_rvalid; captures the word and its address
// S_VALID | instr held stable for decode; accept computes the next pc

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        arst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [5:0]  opcode,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2
   } state_t;

   state_t      state_q, state_nxt;
   logic [31:0] pc_q, pc_nxt;
   logic [31:0] instr_q, instr_nxt;
   logic [31:0] instr_pc_q, instr_pc_nxt;
   logic        valid_q, valid_nxt;
   logic [31:0] count_q, count_nxt;

   logic [31:0] seq_pc;
   logic [31:0] branch_off;
   logic [31:0] jump_pc;
   logic [31:0] target_pc;

   // Next-pc candidates all derive from the captured instruction, never from the live bus.
   always_comb begin
      seq_pc     = instr_pc_q + 32'd4;
      branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      jump_pc    = {seq_pc[31:28], instr_q[25:0], 2'b00};
      target_pc  = seq_pc;
      if (jump) begin
         target_pc = jump_pc;
      end else if (branch && zero) begin
         target_pc = seq_pc + branch_off;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= PC_INIT;
         instr_q    <= 32'd0;
         instr_pc_q <= 32'd0;
         valid_q    <= 1'b0;
         count_q    <= 32'd0;
      end else begin
         state_q    <= state_nxt;
         pc_q       <= pc_nxt;
         instr_q    <= instr_nxt;
         instr_pc_q <= instr_pc_nxt;
         valid_q    <= valid_nxt;
         count_q    <= count_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      pc_nxt       = pc_q;
      instr_nxt    = instr_q;
      instr_pc_nxt = instr_pc_q;
      valid_nxt    = valid_q;
      count_nxt    = count_q;
      case (state_q)
         S_FETCH: begin
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               instr_nxt    = imem_rdata;
               instr_pc_nxt = pc_q;
               valid_nxt    = 1'b1;
               state_nxt    = S_VALID;
            end
         end
         S_VALID: begin
            // a stray imem_rvalid here is deliberately not looked at
            if (valid_q && instr_ready) begin
               pc_nxt    = {target_pc[31:2], 2'b00};
               count_nxt = count_q + 32'd1;
               valid_nxt = 1'b0;
               state_nxt = S_FETCH;
            end
         end
         default: begin
            state_nxt = S_FETCH;
            valid_nxt = 1'b0;
         end
      endcase
   end

   // Reset holds the state in S_FETCH, so the request decode is masked while arst_n is low.
   assign imem_req    = (state_q == S_FETCH) && arst_n;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign opcode      = valid_q ? instr_q[31:26] : 6'h3F;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed next-pc vector table, back-pressure and reset
// sequences, and a randomized run against a transaction-level pc model.

module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [5:0]  opcode;
   logic        branch;
   logic        zero;
   logic        jump;
   logic [31:0] fetch_count;

   int checks = 0;
   int passed = 0;
   int cycle  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_rvalid (imem_rvalid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .branch      (branch),
      .zero        (zero),
      .jump        (jump),
      .fetch_count (fetch_count)
   );

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] word;
      logic        b;
      logic        z;
      logic        j;
      logic [31:0] exp_next;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
   endtask

   // Instruction-level reference: where the program goes after this instruction.
   function automatic logic [31:0] model_next(input logic [31:0] word, input logic [31:0] pc,
                                              input logic b, input logic z, input logic j);
      logic [31:0] seq;
      logic [31:0] off;
      seq = pc + 32'd4;
      off = {{16{word[15]}}, word[15:0]};
      if (j) return {seq[31:28], word[25:0], 2'b00};
      if (b && z) return seq + off * 32'd4;
      return seq;
   endfunction

   function automatic logic [31:0] beq_to(input logic [31:0] from_pc, input logic [31:0] to_pc);
      logic [31:0] diff;
      diff = (to_pc - (from_pc + 32'd4)) >> 2;
      return {6'h04, 10'd0, diff[15:0]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      arst_n      = 1'b0;
      imem_rvalid = 1'b0;
      instr_ready = 1'b0;
      branch = 1'b0; zero = 1'b0; jump = 1'b0;
      @(negedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      #1;
   endtask

   // Serves one fetch: waits for the request, returns word after lat cycles, holds
   // back-pressure for hold cycles, then accepts with the given b/z/j.
   task automatic serve(input logic [31:0] word, input int lat, input logic b, input logic z,
                        input logic j, input int hold, input bit stray,
                        output logic [31:0] req_addr, output logic [31:0] next_addr,
                        output int req_cycle);
      int guard = 0;
      while (!imem_req && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("req_seen", {31'd0, imem_req}, 32'd1);
      req_addr  = imem_addr;
      req_cycle = cycle;
      for (int i = 1; i <= lat; i++) begin
         @(negedge clk);
         check("req_low_wait", {31'd0, imem_req}, 32'd0);
         check("valid_low_wait", {31'd0, instr_valid}, 32'd0);
         check("opcode_gated_wait", {26'd0, opcode}, 32'h3F);
         branch = 1'($urandom); zero = 1'($urandom); jump = 1'($urandom);
         if (i == lat) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word;
         end
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      check("valid_up", {31'd0, instr_valid}, 32'd1);
      check("instr", instr, word);
      check("instr_pc", instr_pc, req_addr);
      check("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
      for (int h = 0; h < hold; h++) begin
         if (stray && h == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~word;
         end
         @(negedge clk);
         imem_rvalid = 1'b0;
         check("hold_instr", instr, word);
         check("hold_instr_pc", instr_pc, req_addr);
         check("hold_opcode", {26'd0, opcode}, {26'd0, word[31:26]});
         check("hold_valid", {31'd0, instr_valid}, 32'd1);
         check("hold_no_req", {31'd0, imem_req}, 32'd0);
      end
      instr_ready = 1'b1;
      branch = b; zero = z; jump = j;
      @(negedge clk);
      instr_ready = 1'b0;
      branch = 1'($urandom); zero = 1'($urandom); jump = 1'($urandom);
      check("valid_drop", {31'd0, instr_valid}, 32'd0);
      check("opcode_idle", {26'd0, opcode}, 32'h3F);
      check("req_after_accept", {31'd0, imem_req}, 32'd1);
      next_addr = imem_addr;
   endtask

   vec_t        vecs[8];
   logic [31:0] a, n, exp_addr, exp_cnt, w;
   int          c, c_prev;

   initial begin
      vecs[0] = '{"beq_taken",      32'h0000_0040, 32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'h0000_003C};
      vecs[1] = '{"beq_untaken",    32'h0000_0040, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_0044};
      vecs[2] = '{"jump_wrap",      32'hFFFF_FFFC, 32'h0800_0010, 1'b0, 1'b0, 1'b1, 32'h0000_0040};
      vecs[3] = '{"jump_priority",  32'h0000_0040, 32'h0800_0010, 1'b1, 1'b1, 1'b1, 32'h0000_0040};
      vecs[4] = '{"zero_no_branch", 32'h0000_0040, 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0044};
      vecs[5] = '{"beq_forward",    32'h0000_0200, 32'h1000_0005, 1'b1, 1'b1, 1'b0, 32'h0000_0218};
      vecs[6] = '{"beq_back_wrap",  32'h0000_0008, 32'h1000_FFFC, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC};
      vecs[7] = '{"jump_max_field", 32'h0000_0100, 32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0FFF_FFFC};

      arst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
      branch = 1'b0; zero = 1'b0; jump = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_opcode", {26'd0, opcode}, 32'h3F);
      check("rst_count", fetch_count, 32'h0);
      arst_n = 1'b1;
      #1;

      // sequential fetch at minimum latency
      for (int k = 0; k < 3; k++) begin
         serve(32'h0000_0000, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, a, n, c);
         check("seq_addr", a, 32'(k * 4));
         if (k > 0) check("seq_period", 32'(c - c_prev), 32'd3);
         c_prev = c;
      end
      check("seq_next", n, 32'hC);
      check("seq_count", fetch_count, 32'd3);

      // back-pressure with a stray response
      serve(32'h8C22_1234, 2, 1'b0, 1'b0, 1'b0, 5, 1'b1, a, n, c);
      check("bp_addr", a, 32'hC);
      check("bp_next", n, 32'h10);
      check("bp_count", fetch_count, 32'd4);

      foreach (vecs[i]) begin
         do_reset();
         serve(beq_to(32'h0, vecs[i].pc), 1, 1'b1, 1'b1, 1'b0, 0, 1'b0, a, n, c);
         check("steer", n, vecs[i].pc);
         serve(vecs[i].word, 2, vecs[i].b, vecs[i].z, vecs[i].j, 1, 1'b0, a, n, c);
         check("vec_pc", a, vecs[i].pc);
         check(vecs[i].name, n, vecs[i].exp_next);
      end

      // reset in the middle of a 4-cycle wait
      do_reset();
      serve(32'h0000_0000, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, a, n, c);
      check("mid_pre_next", n, 32'h4);
      @(negedge clk);
      @(negedge clk);
      #2;
      arst_n = 1'b0;
      #1;
      check("mid_rst_addr", imem_addr, 32'h0);
      check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      check("mid_rst_opcode", {26'd0, opcode}, 32'h3F);
      check("mid_rst_req", {31'd0, imem_req}, 32'd0);
      check("mid_rst_count", fetch_count, 32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      check("mid_rel_req", {31'd0, imem_req}, 32'd1);
      serve(32'h2001_0001, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, a, n, c);
      check("mid_first_addr", a, 32'h0);

      // randomized program walk
      do_reset();
      exp_addr = 32'h0;
      exp_cnt  = 32'h0;
      for (int t = 0; t < 40; t++) begin
         logic rb, rz, rj;
         w  = $urandom;
         rb = 1'($urandom); rz = 1'($urandom); rj = ($urandom_range(0, 3) == 0);
         serve(w, $urandom_range(1, 4), rb, rz, rj, $urandom_range(0, 3),
               1'($urandom), a, n, c);
         check("rnd_addr", a, exp_addr);
         exp_addr = model_next(w, exp_addr, rb, rz, rj);
         exp_cnt  = exp_cnt + 32'd1;
         check("rnd_next", n, exp_addr);
         check("rnd_count", fetch_count, exp_cnt);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
